// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter sharing one combinational ALU
// Ports: clk/rst_n (sync active-low reset); reqN_valid/ready/a/b/gin/shamt per requester;
// alu_a/b/gin/shamt drive the shared ALU, alu_sum/zout/signout return from it;
// resp_valid/ready handshake with resp_id, resp_sum, resp_zout, resp_signout, resp_err.
module alu_arbiter #(
    parameter bit PRIO_FIXED = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    input  logic        req1_valid,
    output logic        req0_ready,
    output logic        req1_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [2:0]  req0_gin,
    input  logic [2:0]  req1_gin,
    input  logic [4:0]  req0_shamt,
    input  logic [4:0]  req1_shamt,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_gin,
    output logic [4:0]  alu_shamt,
    input  logic [31:0] alu_sum,
    input  logic        alu_zout,
    input  logic        alu_signout,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
    output logic [31:0] resp_sum,
    output logic        resp_zout,
    output logic        resp_signout,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t      r_state;
    logic        r_last;
    logic        r_id;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [2:0]  r_gin;
    logic [4:0]  r_shamt;
    logic        w_idle;
    logic        w_grant;
    logic        w_accept;
    logic        w_legal;
    assign w_idle   = r_state == IDLE;
    // on a tie, round-robin favours the requester not granted last
    assign w_grant  = (req0_valid && req1_valid) ? (PRIO_FIXED ? 1'b0 : ~r_last) : req1_valid;
    assign w_accept = w_idle && (req0_valid || req1_valid);
    assign w_legal  = r_gin inside {3'b010, 3'b110, 3'b111, 3'b000, 3'b001, 3'b100};
    assign req0_ready = w_idle && req0_valid && !w_grant;
    assign req1_ready = w_idle && req1_valid && w_grant;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign alu_gin    = r_gin;
    assign alu_shamt  = r_shamt;
    assign resp_valid = r_state == RESP;
    assign resp_id    = r_id;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_id         <= 1'b0;
            r_a          <= '0;
            r_b          <= '0;
            r_gin        <= '0;
            r_shamt      <= '0;
            resp_sum     <= '0;
            resp_zout    <= 1'b0;
            resp_signout <= 1'b0;
            resp_err     <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (w_accept) begin
                    r_a     <= w_grant ? req1_a : req0_a;
                    r_b     <= w_grant ? req1_b : req0_b;
                    r_gin   <= w_grant ? req1_gin : req0_gin;
                    r_shamt <= w_grant ? req1_shamt : req0_shamt;
                    r_id    <= w_grant;
                    r_last  <= w_grant;
                    r_state <= EXEC;
                end
                EXEC: begin
                    // illegal opcodes report a zero result regardless of the ALU
                    resp_sum     <= w_legal ? alu_sum : 32'd0;
                    resp_zout    <= w_legal ? alu_zout : 1'b1;
                    resp_signout <= w_legal && alu_signout;
                    resp_err     <= !w_legal;
                    r_state      <= RESP;
                end
                RESP: if (resp_ready) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed self-checking bench for alu_arbiter
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic rst_n;
    logic req0_valid, req1_valid, req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0] req0_gin, req1_gin;
    logic [4:0] req0_shamt, req1_shamt;
    logic [31:0] alu_a, alu_b, alu_sum;
    logic [2:0] alu_gin;
    logic [4:0] alu_shamt;
    logic alu_zout, alu_signout;
    logic resp_valid, resp_ready, resp_id, resp_zout, resp_signout, resp_err;
    logic [31:0] resp_sum;
    logic p_req0_ready, p_req1_ready, p_resp_valid, p_resp_id, p_resp_zout, p_resp_signout, p_resp_err;
    logic [31:0] p_alu_a, p_alu_b, p_resp_sum;
    logic [2:0] p_alu_gin;
    logic [4:0] p_alu_shamt;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (alu_gin)
            3'b010:  alu_sum = alu_a + alu_b;
            3'b110:  alu_sum = alu_a - alu_b;
            3'b111:  alu_sum = {31'd0, $signed(alu_a) < $signed(alu_b)};
            3'b000:  alu_sum = alu_a & alu_b;
            3'b001:  alu_sum = alu_a | alu_b;
            3'b100:  alu_sum = alu_b >> alu_shamt;
            default: alu_sum = 32'hDEADBEEF;
        endcase
        alu_zout    = alu_sum == 32'd0;
        alu_signout = alu_sum[31];
    end

    alu_arbiter #(.PRIO_FIXED(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_gin(req0_gin), .req1_gin(req1_gin),
        .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
        .alu_a(alu_a), .alu_b(alu_b), .alu_gin(alu_gin), .alu_shamt(alu_shamt),
        .alu_sum(alu_sum), .alu_zout(alu_zout), .alu_signout(alu_signout),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_zout(resp_zout), .resp_signout(resp_signout),
        .resp_err(resp_err)
    );

    alu_arbiter #(.PRIO_FIXED(1'b1)) dut_p (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req1_valid(req1_valid),
        .req0_ready(p_req0_ready), .req1_ready(p_req1_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req1_a(req1_a), .req1_b(req1_b),
        .req0_gin(req0_gin), .req1_gin(req1_gin),
        .req0_shamt(req0_shamt), .req1_shamt(req1_shamt),
        .alu_a(p_alu_a), .alu_b(p_alu_b), .alu_gin(p_alu_gin), .alu_shamt(p_alu_shamt),
        .alu_sum(p_alu_a + p_alu_b), .alu_zout(p_alu_a + p_alu_b == 32'd0),
        .alu_signout(1'b0),
        .resp_valid(p_resp_valid), .resp_ready(resp_ready), .resp_id(p_resp_id),
        .resp_sum(p_resp_sum), .resp_zout(p_resp_zout), .resp_signout(p_resp_signout),
        .resp_err(p_resp_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset();
        tick();
        #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", resp_valid); end
        total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b%b exp=00", req0_ready, req1_ready); end
        total++; if (resp_sum !== 32'd0) begin bad++; $display("FAIL reset_sum got=%h exp=0", resp_sum); end
        total++; if ({resp_id, resp_zout, resp_signout, resp_err} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b exp=0000", {resp_id, resp_zout, resp_signout, resp_err}); end
        total++; if (alu_a !== 32'd0 || alu_gin !== 3'd0) begin bad++; $display("FAIL reset_alu got=%h/%h exp=0/0", alu_a, alu_gin); end
    endtask

    task automatic test_add;
        req0_a = 32'd5; req0_b = 32'd7; req0_gin = 3'b010; req0_valid = 1'b1; resp_ready = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin bad++; $display("FAIL add_ready got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0;
        #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL add_exec_valid got=%b exp=0", resp_valid); end
        total++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin bad++; $display("FAIL add_alu got=%h/%h exp=5/7", alu_a, alu_b); end
        tick();
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", resp_valid); end
        total++; if (resp_sum !== 32'd12) begin bad++; $display("FAIL add_sum got=%h exp=c", resp_sum); end
        total++; if ({resp_id, resp_zout, resp_err} !== 3'b000) begin bad++; $display("FAIL add_flags got=%b exp=000", {resp_id, resp_zout, resp_err}); end
        tick();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL add_done got=%b exp=0", resp_valid); end
    endtask

    task automatic test_round_robin;
        do_reset();
        req0_a = 32'd3; req0_b = 32'd3; req0_gin = 3'b110;
        req1_a = 32'd2; req1_b = 32'd9; req1_gin = 3'b111;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if ({req0_ready, req1_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin bad++; $display("FAIL rr_grant%0d got=%b%b", i, req0_ready, req1_ready); end
            tick();
            total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL rr_exec_ready%0d got=%b%b exp=00", i, req0_ready, req1_ready); end
            tick();
            total++; if (resp_valid !== 1'b1 || resp_id !== (i % 2 == 1)) begin bad++; $display("FAIL rr_id%0d got=%b/%b exp=1/%0d", i, resp_valid, resp_id, i % 2); end
            total++; if (resp_sum !== ((i % 2 == 1) ? 32'd1 : 32'd0) || resp_zout !== (i % 2 == 0)) begin bad++; $display("FAIL rr_result%0d got=%h/%b", i, resp_sum, resp_zout); end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_fixed;
        do_reset();
        req0_a = 32'd1; req0_b = 32'd1; req0_gin = 3'b010;
        req1_a = 32'd4; req1_b = 32'd4; req1_gin = 3'b010;
        req0_valid = 1'b1; req1_valid = 1'b1; resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if ({p_req0_ready, p_req1_ready} !== 2'b10) begin bad++; $display("FAIL fixed_grant%0d got=%b%b exp=10", i, p_req0_ready, p_req1_ready); end
            tick();
            total++; if (p_req1_ready !== 1'b0) begin bad++; $display("FAIL fixed_r1_%0d got=%b exp=0", i, p_req1_ready); end
            tick();
            total++; if (p_resp_valid !== 1'b1 || p_resp_id !== 1'b0 || p_resp_sum !== 32'd2) begin bad++; $display("FAIL fixed_resp%0d got=%b/%b/%h exp=1/0/2", i, p_resp_valid, p_resp_id, p_resp_sum); end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_backpressure;
        req1_a = 32'd0; req1_b = 32'h80000000; req1_gin = 3'b100; req1_shamt = 5'd4;
        req1_valid = 1'b1; resp_ready = 1'b0;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b01) begin bad++; $display("FAIL bp_grant got=%b%b exp=01", req0_ready, req1_ready); end
        tick();
        req1_valid = 1'b0;
        tick();
        req0_valid = 1'b1; req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            total++; if (resp_valid !== 1'b1 || resp_sum !== 32'h08000000 || resp_id !== 1'b1) begin bad++; $display("FAIL bp_hold%0d got=%b/%h/%b exp=1/08000000/1", i, resp_valid, resp_sum, resp_id); end
            total++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%b%b exp=00", i, req0_ready, req1_ready); end
            tick();
        end
        resp_ready = 1'b1;
        tick();
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", resp_valid); end
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL bp_next_grant got=%b%b exp=10", req0_ready, req1_ready); end
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_illegal;
        req0_a = 32'd1; req0_b = 32'd2; req0_gin = 3'b011; req0_valid = 1'b1; resp_ready = 1'b1;
        #1;
        total++; if (req0_ready !== 1'b1) begin bad++; $display("FAIL ill_ready got=%b exp=1", req0_ready); end
        tick();
        req0_valid = 1'b0;
        tick();
        total++; if (resp_err !== 1'b1 || resp_sum !== 32'd0) begin bad++; $display("FAIL ill_result got=%b/%h exp=1/0", resp_err, resp_sum); end
        total++; if (resp_zout !== 1'b1 || resp_signout !== 1'b0) begin bad++; $display("FAIL ill_flags got=%b%b exp=10", resp_zout, resp_signout); end
        tick();
    endtask

    task automatic test_reset_in_resp;
        req0_a = 32'd1; req0_b = 32'd1; req0_gin = 3'b010; req0_valid = 1'b1; resp_ready = 1'b0;
        #1;
        tick();
        req0_valid = 1'b0;
        tick();
        total++; if (resp_valid !== 1'b1 || resp_sum !== 32'd2) begin bad++; $display("FAIL rr_pre got=%b/%h exp=1/2", resp_valid, resp_sum); end
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        #1;
        total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL rst_glitch got=%b exp=1", resp_valid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
        total++; if (resp_sum !== 32'd0 || {resp_id, resp_zout, resp_signout, resp_err} !== 4'b0000) begin bad++; $display("FAIL rst_resp_out got=%h/%b exp=0/0000", resp_sum, {resp_id, resp_zout, resp_signout, resp_err}); end
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        total++; if ({req0_ready, req1_ready} !== 2'b10) begin bad++; $display("FAIL rst_tie got=%b%b exp=10", req0_ready, req1_ready); end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b1;
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; resp_ready = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        req0_gin = '0; req1_gin = '0; req0_shamt = '0; req1_shamt = '0;
        test_reset();
        test_add();
        test_round_robin();
        test_fixed();
        test_backpressure();
        test_illegal();
        test_reset_in_resp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter PRIO_FIXED, default 0, meaning 0 = round-robin arbitration, 1 = requester 0 always wins ties.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock.
REQ-003 The block SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1  requester n has an operation pending.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1  operation of requester n accepted this cycle.
REQ-006 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32  operands of requester n.
REQ-007 The block SHALL have ports req0_gin / req1_gin  input  3  ALU control line of requester n.
REQ-008 The block SHALL have ports req0_shamt / req1_shamt  input  5  shift amount of requester n.
REQ-009 The block SHALL have ports alu_a, alu_b  output  32  and alu_gin  output  3  and alu_shamt  output  5  driving the shared ALU.
REQ-010 The block SHALL have ports alu_sum  input  32  and alu_zout, alu_signout  input  1  returned from the shared ALU (combinational).
REQ-011 The block SHALL have port resp_valid  output  1  result available.
REQ-012 The block SHALL have port resp_ready  input  1  consumer takes the result.
REQ-013 The block SHALL have port resp_id  output  1  requester that owns the result.
REQ-014 The block SHALL have ports resp_sum  output  32  and resp_zout, resp_signout, resp_err  output  1  registered result, flags, illegal-opcode flag.

Function
REQ-015 The FSM SHALL have states IDLE, EXEC, RESP; IDLE->EXEC on acceptance, EXEC->RESP unconditionally, RESP->IDLE on resp_valid && resp_ready, otherwise it stays in RESP.
REQ-016 In IDLE, if exactly one reqn_valid is high, that requester SHALL be granted; if both are high, the requester not granted last SHALL win (PRIO_FIXED=0) or requester 0 SHALL win (PRIO_FIXED=1).
REQ-017 reqn_ready SHALL be high only in IDLE, only for the granted requester, and only when its reqn_valid is high; it SHALL be combinational from state and valids.
REQ-018 On acceptance, a, b, gin, shamt and the requester id SHALL be captured into internal registers, and last-grant SHALL be updated to that id.
REQ-019 alu_a, alu_b, alu_gin, alu_shamt SHALL always drive the captured registers, never requester inputs directly.
REQ-020 In EXEC, alu_sum, alu_zout, alu_signout SHALL be registered into resp_sum, resp_zout, resp_signout at the clock edge ending EXEC.
REQ-021 Legal gin values SHALL be 010 ADD, 110 SUB, 111 SLT, 000 AND, 001 OR, 100 SRL; any other gin SHALL yield resp_err=1, resp_sum=0, resp_zout=1, resp_signout=0, and ALU outputs SHALL be ignored.
REQ-022 resp_valid SHALL be high exactly while in RESP; resp_sum, flags, resp_id SHALL hold stable until the handshake.
REQ-023 Latency: accepted at edge N, resp_valid SHALL be high in the cycle after edge N+1; with resp_ready tied high, throughput SHALL be one operation per 3 cycles.
REQ-024 Requests arriving in EXEC or RESP SHALL see reqn_ready=0 and SHALL be arbitrated in the next IDLE cycle; a requester dropping valid before ready SHALL not be granted.
REQ-025 Arithmetic widths SHALL follow the ALU: 32-bit wrap-around, no overflow flag generated or checked.

Reset
REQ-026 While rst_n=0 at a clock edge, state SHALL become IDLE, last-grant SHALL become 1 (requester 0 wins the first tie), and captured registers, resp_sum, resp_id, resp_zout, resp_signout, resp_err SHALL become 0.
REQ-027 After reset, resp_valid=0 and req0_ready/req1_ready SHALL be low; any in-flight operation (EXEC or RESP) SHALL be discarded without producing a response.
REQ-028 rst_n SHALL have no effect between clock edges.

Verification
REQ-029 Single ADD: req0 a=5, b=7, gin=010 -> req0_ready same cycle, resp_valid 2 cycles later, resp_sum=12, resp_id=0, zout=0, err=0.
REQ-030 Tie, round-robin: both valid continuously, req0 SUB 3-3, req1 SLT 2,9 -> grants 0,1,0,1; resp_sum=0 with zout=1 for id 0; resp_sum=1 for id 1.
REQ-031 PRIO_FIXED=1, both valid for 3 operations -> all three grants to requester 0, req1_ready stays 0.
REQ-032 Backpressure: resp_ready=0 for 5 cycles in RESP with req1 SRL b=0x80000000, shamt=4 -> resp_sum=0x08000000 held stable, req0/req1_ready low, IDLE one cycle after resp_ready=1.
REQ-033 Illegal gin=011 -> resp_err=1, resp_sum=0, resp_zout=1, regardless of alu_sum value.
REQ-034 rst_n=0 for one edge during RESP -> next cycle resp_valid=0, outputs all 0, and first post-reset tie granted to requester 0.
